// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiply is radix-2 shift-add and divide is restoring division; each takes
// DATA_W cycles in CALC. FIX applies signs, accumulation and divide-by-zero.
module execute_muldiv #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_opa,
  input  logic [DATA_W-1:0] i_opb,
  input  logic [DATA_W-1:0] i_hi_in,
  input  logic [DATA_W-1:0] i_lo_in,
  input  logic              i_annul,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi_out,
  output logic [DATA_W-1:0] o_lo_out,
  output logic              o_div_by_zero
);

  localparam int unsigned CntW = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [CntW-1:0]       r_cnt;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic                  r_is_div;
  logic                  r_is_acc;
  logic                  r_is_sub;
  logic                  r_dbz;
  logic [2*DATA_W-1:0]   r_acc;
  logic [2*DATA_W-1:0]   r_prod;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_hi_out;
  logic [DATA_W-1:0]     r_lo_out;
  logic                  r_div_by_zero;

  logic                  w_accept;
  logic                  w_in_div;
  logic                  w_in_signed;
  logic                  w_in_dbz;
  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic                  w_last;
  logic [DATA_W:0]       w_sum;
  logic [DATA_W:0]       w_shift;
  logic                  w_ge;
  logic [DATA_W-1:0]     w_diff;
  logic                  w_neg;
  logic [2*DATA_W-1:0]   w_prod_s;
  logic [2*DATA_W-1:0]   w_mac;
  logic [DATA_W-1:0]     w_fix_hi;
  logic [DATA_W-1:0]     w_fix_lo;

  // Request decode and operand magnitudes.
  always_comb begin
    w_accept    = ((r_state == StIdle) || (r_state == StDone)) && i_start && !i_annul;
    w_in_div    = (i_op[2:1] == 2'b01);
    w_in_signed = ~i_op[0];
    w_in_dbz    = w_in_div && (i_opb == '0);
    w_abs_a     = (w_in_signed && i_opa[DATA_W-1]) ? -i_opa : i_opa;
    w_abs_b     = (w_in_signed && i_opb[DATA_W-1]) ? -i_opb : i_opb;
    w_last      = (r_cnt == CntW'(DATA_W - 1));
  end

  // One iteration step: shift-add for multiply, trial subtract for divide.
  always_comb begin
    w_sum   = {1'b0, r_prod[2*DATA_W-1:DATA_W]} + (r_prod[0] ? {1'b0, r_a} : '0);
    w_shift = {r_rem, r_quo[DATA_W-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    // The partial remainder never exceeds 2*b, so the low DATA_W bits suffice.
    w_diff  = w_shift[DATA_W-1:0] - r_b;
  end

  // Result formation in FIX.
  always_comb begin
    w_neg    = r_sign_a ^ r_sign_b;
    w_prod_s = w_neg ? -r_prod : r_prod;
    w_mac    = w_prod_s;
    if (r_is_acc) begin
      w_mac = r_is_sub ? (r_acc - w_prod_s) : (r_acc + w_prod_s);
    end
    w_fix_hi = w_mac[2*DATA_W-1:DATA_W];
    w_fix_lo = w_mac[DATA_W-1:0];
    if (r_is_div) begin
      if (r_dbz) begin
        w_fix_hi = r_sign_a ? -r_a : r_a;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_sign_a ? -r_rem : r_rem;
        w_fix_lo = w_neg ? -r_quo : r_quo;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state logic; annul overrides everything.
  always_comb begin
    w_state_next = r_state;
    if (i_annul) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (w_accept) w_state_next = w_in_dbz ? StFix : StCalc;
          else          w_state_next = StIdle;
        end
        StCalc: if (w_last) w_state_next = StFix;
        StFix:  w_state_next = StDone;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Datapath and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_is_div      <= 1'b0;
      r_is_acc      <= 1'b0;
      r_is_sub      <= 1'b0;
      r_dbz         <= 1'b0;
      r_acc         <= '0;
      r_prod        <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_hi_out      <= '0;
      r_lo_out      <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_a      <= w_abs_a;
        r_b      <= w_abs_b;
        r_sign_a <= w_in_signed & i_opa[DATA_W-1];
        r_sign_b <= w_in_signed & i_opb[DATA_W-1];
        r_is_div <= w_in_div;
        r_is_acc <= i_op[2];
        r_is_sub <= i_op[2] & i_op[1];
        r_dbz    <= w_in_dbz;
        r_acc    <= {i_hi_in, i_lo_in};
        r_prod   <= {{DATA_W{1'b0}}, w_abs_b};
        r_rem    <= '0;
        r_quo    <= w_abs_a;
      end else if ((r_state == StCalc) && !i_annul) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_rem <= w_ge ? w_diff : w_shift[DATA_W-1:0];
          r_quo <= {r_quo[DATA_W-2:0], w_ge};
        end else begin
          r_prod <= {w_sum, r_prod[DATA_W-1:1]};
        end
      end
      if ((r_state == StFix) && !i_annul) begin
        r_hi_out      <= w_fix_hi;
        r_lo_out      <= w_fix_lo;
        r_div_by_zero <= r_dbz;
      end
    end
  end

  assign o_busy        = (r_state == StCalc) || (r_state == StFix);
  assign o_done        = (r_state == StDone);
  assign o_hi_out      = r_hi_out;
  assign o_lo_out      = r_lo_out;
  assign o_div_by_zero = r_div_by_zero;

endmodule
